// File: rtl/sobel_window_engine.sv
// Sobel window engine: walks the image in 4-px x 3-row windows, fetches each window from the
// line buffer and writes |Gx|+|Gy| of the two centre pixels. SOBEL_THRESH_EN binarises the output.
module sobel_window_engine (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [11:0] image_width,
    input  logic [11:0] image_height,
`ifdef SOBEL_THRESH_EN
    input  logic [7:0]  thresh,
`endif
    output logic [19:0] ED_rpixNum,
    output logic        fill_buff,
    input  logic        buff_filled,
    input  logic [95:0] ED_rdata,
    output logic        wr_en,
    input  logic        wr_ack,
    output logic [19:0] wr_pixNum,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_CALC, S_WRITE, S_RELEASE, S_ADV, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_width;
    logic [11:0] r_height;
    logic [11:0] r_row;
    logic [11:0] r_col;
    logic [19:0] r_basePix;
    logic [19:0] r_wrPix;
    logic [15:0] r_wrData;
    logic        w_lastWin;
    logic        w_rowEnd;
    logic [31:0] w_r0;
    logic [31:0] w_r1;
    logic [31:0] w_r2;
    logic [7:0]  w_px1;
    logic [7:0]  w_px2;
    logic [7:0]  w_out1;
    logic [7:0]  w_out2;

    // Saturated |Gx|+|Gy| from the 8 neighbours; the centre pixel itself carries no weight.
    function automatic logic [7:0] sobelPx(input logic [7:0] tl, tm, tr, ml, mr, bl, bm, br);
        logic [9:0]  sl, sr, st, sb;
        logic [10:0] gx, gy, ax, ay;
        logic [11:0] mag;
        sl  = {2'b00, tl} + {1'b0, ml, 1'b0} + {2'b00, bl};
        sr  = {2'b00, tr} + {1'b0, mr, 1'b0} + {2'b00, br};
        st  = {2'b00, tl} + {1'b0, tm, 1'b0} + {2'b00, tr};
        sb  = {2'b00, bl} + {1'b0, bm, 1'b0} + {2'b00, br};
        gx  = {1'b0, sr} - {1'b0, sl};
        gy  = {1'b0, sb} - {1'b0, st};
        ax  = gx[10] ? (~gx + 11'd1) : gx;
        ay  = gy[10] ? (~gy + 11'd1) : gy;
        mag = {1'b0, ax} + {1'b0, ay};
        return (mag > 12'd255) ? 8'hFF : mag[7:0];
    endfunction

    assign w_r0 = ED_rdata[31:0];
    assign w_r1 = ED_rdata[63:32];
    assign w_r2 = ED_rdata[95:64];

    assign w_px1 = sobelPx(w_r0[7:0],  w_r0[15:8],  w_r0[23:16], w_r1[7:0],  w_r1[23:16],
                           w_r2[7:0],  w_r2[15:8],  w_r2[23:16]);
    assign w_px2 = sobelPx(w_r0[15:8], w_r0[23:16], w_r0[31:24], w_r1[15:8], w_r1[31:24],
                           w_r2[15:8], w_r2[23:16], w_r2[31:24]);

`ifdef SOBEL_THRESH_EN
    logic [7:0] r_thresh;
    assign w_out1 = (w_px1 >= r_thresh) ? 8'hFF : 8'h00;
    assign w_out2 = (w_px2 >= r_thresh) ? 8'hFF : 8'h00;
`else
    assign w_out1 = w_px1;
    assign w_out2 = w_px2;
`endif

    assign w_rowEnd  = (r_col == r_width - 12'd4);
    assign w_lastWin = (r_row == r_height - 12'd3) && w_rowEnd;

    assign ED_rpixNum = r_basePix;
    assign wr_pixNum  = r_wrPix;
    assign wr_data    = r_wrData;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_FILL;
            S_FILL:    if (buff_filled) w_next = S_CALC;
            S_CALC:    w_next = S_WRITE;
            S_WRITE:   if (wr_ack) w_next = S_RELEASE;
            S_RELEASE: if (!buff_filled) w_next = S_ADV;
            S_ADV:     w_next = w_lastWin ? S_DONE : S_FILL;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // fill_buff stays up while the window is in use so the buffer keeps ED_rdata steady until the write is acked.
    always_comb begin
        fill_buff = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            S_IDLE:  busy = 1'b0;
            S_FILL:  fill_buff = 1'b1;
            S_CALC:  fill_buff = 1'b1;
            S_WRITE: begin
                fill_buff = 1'b1;
                wr_en     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_width   <= '0;
            r_height  <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_basePix <= '0;
            r_wrPix   <= '0;
            r_wrData  <= '0;
`ifdef SOBEL_THRESH_EN
            r_thresh  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_width   <= image_width;
                    r_height  <= image_height;
                    r_row     <= '0;
                    r_col     <= '0;
                    r_basePix <= '0;
`ifdef SOBEL_THRESH_EN
                    r_thresh  <= thresh;
`endif
                end
                S_CALC: begin
                    r_wrData <= {w_out2, w_out1};
                    r_wrPix  <= r_basePix + {8'd0, r_width} + 20'd1;
                end
                // Stepping past the last two columns of a row lands on the next row's start: +4, not +2.
                S_ADV: if (!w_lastWin) begin
                    if (w_rowEnd) begin
                        r_row     <= r_row + 12'd1;
                        r_col     <= '0;
                        r_basePix <= r_basePix + 20'd4;
                    end else begin
                        r_col     <= r_col + 12'd2;
                        r_basePix <= r_basePix + 20'd2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_window_engine.sv
// Directed self-checking bench for sobel_window_engine (uses SOBEL_THRESH_EN when defined).
module tb_sobel_window_engine;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] image_width = '0;
    logic [11:0] image_height = '0;
`ifdef SOBEL_THRESH_EN
    logic [7:0]  thresh = 8'h10;
`endif
    logic [19:0] ED_rpixNum;
    logic        fill_buff;
    logic        buff_filled = 1'b0;
    logic [95:0] ED_rdata = '0;
    logic        wr_en;
    logic        wr_ack = 1'b0;
    logic [19:0] wr_pixNum;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;

    sobel_window_engine dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .image_width(image_width),
        .image_height(image_height),
`ifdef SOBEL_THRESH_EN
        .thresh(thresh),
`endif
        .ED_rpixNum(ED_rpixNum),
        .fill_buff(fill_buff),
        .buff_filled(buff_filled),
        .ED_rdata(ED_rdata),
        .wr_en(wr_en),
        .wr_ack(wr_ack),
        .wr_pixNum(wr_pixNum),
        .wr_data(wr_data),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nPass = 0;
    logic [19:0] fillLog[16];
    logic [19:0] wrPixLog[16];
    logic [15:0] wrDataLog[16];
    int          nFill;
    int          nWr;
    int          nDone;
    bit          timedOut;

    typedef struct {
        logic [31:0] r0;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [15:0] mag;
        string       name;
    } pat_t;

    function automatic logic [15:0] expOut(input logic [15:0] m);
`ifdef SOBEL_THRESH_EN
        return {(m[15:8] >= 8'h10) ? 8'hFF : 8'h00, (m[7:0] >= 8'h10) ? 8'hFF : 8'h00};
`else
        return m;
`endif
    endfunction

    task automatic setRows(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
        ED_rdata = {r2, r1, r0};
    endtask

    // Plays the buffer and writer with one-cycle fill response and immediate ack, logging traffic.
    task automatic runFrame(input logic [11:0] w, input logic [11:0] h, input bit pokeStart);
        int cyc;
        bit prevFill;
        bit finished;
        bit poked;
        nFill = 0; nWr = 0; nDone = 0; timedOut = 0;
        image_width = w; image_height = h;
        buff_filled = 1'b0; wr_ack = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0; prevFill = 0; finished = 0; poked = 0;
        while (!finished) begin
            start = 1'b0;
            if (fill_buff && !prevFill) begin
                if (nFill < 16) fillLog[nFill] = ED_rpixNum;
                nFill++;
            end
            prevFill = fill_buff;
            buff_filled = fill_buff;
            if (wr_en) begin
                if (nWr < 16) begin
                    wrPixLog[nWr]  = wr_pixNum;
                    wrDataLog[nWr] = wr_data;
                end
                nWr++;
                wr_ack = 1'b1;
                if (pokeStart && !poked) begin
                    start = 1'b1;
                    poked = 1;
                end
            end else begin
                wr_ack = 1'b0;
            end
            if (done) begin
                nDone++;
                finished = 1;
            end
            cyc++;
            if (cyc > 400) begin
                timedOut = 1;
                finished = 1;
            end
            @(negedge clk);
        end
        start = 1'b0; buff_filled = 1'b0; wr_ack = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++; if (fill_buff !== 1'b0) $display("[TB] FAIL reset_fill_buff got %b want 0", fill_buff); else nPass++;
        nChecks++; if (wr_en !== 1'b0) $display("[TB] FAIL reset_wr_en got %b want 0", wr_en); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else nPass++;
        nChecks++; if (done !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done); else nPass++;
        nChecks++; if (ED_rpixNum !== 20'd0) $display("[TB] FAIL reset_rpix got %0d want 0", ED_rpixNum); else nPass++;
        nChecks++; if (wr_data !== 16'h0) $display("[TB] FAIL reset_wr_data got %h want 0000", wr_data); else nPass++;
        nChecks++; if (wr_pixNum !== 20'd0) $display("[TB] FAIL reset_wr_pix got %0d want 0", wr_pixNum); else nPass++;
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat();
        logic [19:0] expPix[3] = '{20'd9, 20'd11, 20'd13};
        logic [19:0] expFill[3] = '{20'd0, 20'd2, 20'd4};
        setRows(32'h40404040, 32'h40404040, 32'h40404040);
        runFrame(12'd8, 12'd3, 1'b0);
        nChecks++; if (timedOut) $display("[TB] FAIL flat_timeout got 1 want 0"); else nPass++;
        nChecks++; if (nWr !== 3) $display("[TB] FAIL flat_writes got %0d want 3", nWr); else nPass++;
        nChecks++; if (nDone !== 1) $display("[TB] FAIL flat_done got %0d want 1", nDone); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL flat_idle_busy got %b want 0", busy); else nPass++;
        for (int i = 0; i < 3; i++) begin
            nChecks++; if (wrPixLog[i] !== expPix[i]) $display("[TB] FAIL flat_wr_pix[%0d] got %0d want %0d", i, wrPixLog[i], expPix[i]); else nPass++;
            nChecks++; if (wrDataLog[i] !== expOut(16'h0000)) $display("[TB] FAIL flat_wr_data[%0d] got %h want %h", i, wrDataLog[i], expOut(16'h0000)); else nPass++;
            nChecks++; if (fillLog[i] !== expFill[i]) $display("[TB] FAIL flat_rpix[%0d] got %0d want %0d", i, fillLog[i], expFill[i]); else nPass++;
        end
    endtask

    task automatic test_patterns();
        pat_t pats[7];
        pats[0] = '{32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 16'hFFFF, "vert_edge"};
        pats[1] = '{32'h03020100, 32'h03020100, 32'h03020100, 16'h0808, "ramp"};
        pats[2] = '{32'h00000000, 32'h55555555, 32'h10101010, 16'h4040, "gy_pos"};
        pats[3] = '{32'h20202020, 32'h00000000, 32'h00000000, 16'h8080, "gy_neg"};
        pats[4] = '{32'h03020100, 32'h03020100, 32'h13121110, 16'h4848, "mixed"};
        pats[5] = '{32'h00000000, 32'h00000000, 32'h3F3F3F3F, 16'hFCFC, "below_sat"};
        pats[6] = '{32'h00000000, 32'h00000000, 32'h40404040, 16'hFFFF, "sat_256"};
        for (int i = 0; i < 7; i++) begin
            setRows(pats[i].r0, pats[i].r1, pats[i].r2);
            runFrame(12'd4, 12'd3, 1'b0);
            nChecks++; if (nWr !== 1) $display("[TB] FAIL %s_writes got %0d want 1", pats[i].name, nWr); else nPass++;
            nChecks++; if (wrDataLog[0] !== expOut(pats[i].mag)) $display("[TB] FAIL %s_data got %h want %h", pats[i].name, wrDataLog[0], expOut(pats[i].mag)); else nPass++;
            nChecks++; if (wrPixLog[0] !== 20'd5) $display("[TB] FAIL %s_wr_pix got %0d want 5", pats[i].name, wrPixLog[0]); else nPass++;
        end
    endtask

    task automatic test_traversal();
        logic [19:0] expFill[4] = '{20'd0, 20'd2, 20'd6, 20'd8};
        logic [19:0] expPix[4] = '{20'd7, 20'd9, 20'd13, 20'd15};
        setRows(32'h40404040, 32'h40404040, 32'h40404040);
        runFrame(12'd6, 12'd4, 1'b0);
        nChecks++; if (nFill !== 4) $display("[TB] FAIL trav_fills got %0d want 4", nFill); else nPass++;
        nChecks++; if (nDone !== 1) $display("[TB] FAIL trav_done got %0d want 1", nDone); else nPass++;
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (fillLog[i] !== expFill[i]) $display("[TB] FAIL trav_rpix[%0d] got %0d want %0d", i, fillLog[i], expFill[i]); else nPass++;
            nChecks++; if (wrPixLog[i] !== expPix[i]) $display("[TB] FAIL trav_wr_pix[%0d] got %0d want %0d", i, wrPixLog[i], expPix[i]); else nPass++;
        end
    endtask

    task automatic test_start_ignored();
        setRows(32'h40404040, 32'h40404040, 32'h40404040);
        runFrame(12'd6, 12'd3, 1'b1);
        nChecks++; if (nWr !== 2) $display("[TB] FAIL busy_start_writes got %0d want 2", nWr); else nPass++;
        nChecks++; if (wrPixLog[1] !== 20'd9) $display("[TB] FAIL busy_start_wr_pix got %0d want 9", wrPixLog[1]); else nPass++;
        nChecks++; if (nDone !== 1) $display("[TB] FAIL busy_start_done got %0d want 1", nDone); else nPass++;
    endtask

    task automatic test_back_pressure();
        int cyc;
        bit sawDone;
        setRows(32'h03020100, 32'h03020100, 32'h03020100);
        image_width = 12'd6; image_height = 12'd3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!wr_en && cyc < 20) begin
            buff_filled = fill_buff;
            @(negedge clk);
            cyc++;
        end
        nChecks++; if (wr_en !== 1'b1) $display("[TB] FAIL hold_reach_write got %b want 1", wr_en); else nPass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nChecks++; if (wr_en !== 1'b1) $display("[TB] FAIL hold_wr_en[%0d] got %b want 1", i, wr_en); else nPass++;
            nChecks++; if (wr_data !== expOut(16'h0808)) $display("[TB] FAIL hold_wr_data[%0d] got %h want %h", i, wr_data, expOut(16'h0808)); else nPass++;
            nChecks++; if (wr_pixNum !== 20'd7) $display("[TB] FAIL hold_wr_pix[%0d] got %0d want 7", i, wr_pixNum); else nPass++;
            nChecks++; if (fill_buff !== 1'b1) $display("[TB] FAIL hold_fill_buff[%0d] got %b want 1", i, fill_buff); else nPass++;
        end
        wr_ack = 1'b1;
        @(negedge clk) wr_ack = 1'b0;
        nChecks++; if (wr_en !== 1'b0) $display("[TB] FAIL ack_wr_en got %b want 0", wr_en); else nPass++;
        nChecks++; if (fill_buff !== 1'b0) $display("[TB] FAIL ack_fill_buff got %b want 0", fill_buff); else nPass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nChecks++; if (fill_buff !== 1'b0) $display("[TB] FAIL release_fill_buff[%0d] got %b want 0", i, fill_buff); else nPass++;
            nChecks++; if (ED_rpixNum !== 20'd0) $display("[TB] FAIL release_rpix[%0d] got %0d want 0", i, ED_rpixNum); else nPass++;
        end
        buff_filled = 1'b0;
        cyc = 0;
        while (!fill_buff && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        nChecks++; if (fill_buff !== 1'b1) $display("[TB] FAIL next_fill got %b want 1", fill_buff); else nPass++;
        nChecks++; if (ED_rpixNum !== 20'd2) $display("[TB] FAIL next_rpix got %0d want 2", ED_rpixNum); else nPass++;
        sawDone = 0; cyc = 0;
        while (!sawDone && cyc < 50) begin
            buff_filled = fill_buff;
            wr_ack = wr_en;
            if (done) sawDone = 1;
            @(negedge clk);
            cyc++;
        end
        buff_filled = 1'b0; wr_ack = 1'b0;
        nChecks++; if (sawDone !== 1'b1) $display("[TB] FAIL hold_frame_done got %b want 1", sawDone); else nPass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        setRows(32'h40404040, 32'h40404040, 32'h40404040);
        image_width = 12'd8; image_height = 12'd3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!(wr_en && ED_rpixNum == 20'd2) && cyc < 60) begin
            buff_filled = fill_buff;
            wr_ack = wr_en;
            @(negedge clk);
            cyc++;
        end
        wr_ack = 1'b0;
        nChecks++; if (wr_en !== 1'b1) $display("[TB] FAIL mid_reach_write got %b want 1", wr_en); else nPass++;
        nChecks++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy got %b want 1", busy); else nPass++;
        n_rst = 1'b0;
        #1;
        nChecks++; if (wr_en !== 1'b0) $display("[TB] FAIL mid_rst_wr_en got %b want 0", wr_en); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL mid_rst_busy got %b want 0", busy); else nPass++;
        nChecks++; if (fill_buff !== 1'b0) $display("[TB] FAIL mid_rst_fill got %b want 0", fill_buff); else nPass++;
        nChecks++; if (done !== 1'b0) $display("[TB] FAIL mid_rst_done got %b want 0", done); else nPass++;
        nChecks++; if (ED_rpixNum !== 20'd0) $display("[TB] FAIL mid_rst_rpix got %0d want 0", ED_rpixNum); else nPass++;
        nChecks++; if (wr_data !== 16'h0) $display("[TB] FAIL mid_rst_wr_data got %h want 0000", wr_data); else nPass++;
        nChecks++; if (wr_pixNum !== 20'd0) $display("[TB] FAIL mid_rst_wr_pix got %0d want 0", wr_pixNum); else nPass++;
        buff_filled = 1'b0;
        @(negedge clk) n_rst = 1'b1;
        runFrame(12'd8, 12'd3, 1'b0);
        nChecks++; if (fillLog[0] !== 20'd0) $display("[TB] FAIL restart_rpix got %0d want 0", fillLog[0]); else nPass++;
        nChecks++; if (nWr !== 3) $display("[TB] FAIL restart_writes got %0d want 3", nWr); else nPass++;
        nChecks++; if (wrPixLog[0] !== 20'd9) $display("[TB] FAIL restart_wr_pix got %0d want 9", wrPixLog[0]); else nPass++;
        nChecks++; if (nDone !== 1) $display("[TB] FAIL restart_done got %0d want 1", nDone); else nPass++;
    endtask

    initial begin
        test_reset();
        test_flat();
        test_patterns();
        test_traversal();
        test_start_ignored();
        test_back_pressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
